// File: rtl/adc_serial_capture_if.sv
// AXI4-Stream beat bus carrying one sign-extended ADC sample per channel.
interface adc_serial_capture_if;
   logic [31:0] tdata;
   logic [3:0]  tuser;
   logic        tlast;
   logic        tvalid;
   logic        tready;

   modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
   modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);
endinterface

// File: rtl/adc_serial_capture.sv
// Serial ADC deserializer: shifts N_CH lanes MSB-first between word_sync pulses,
// parks each finished frame in a one-frame holding buffer and replays it as a
// channel-serialized AXI4-Stream. Overruns and mid-frame syncs are flagged.
module adc_serial_capture #(
   parameter int N_CH     = 8,
   parameter int ADC_BITS = 18
) (
   input  logic             data_clk,
   input  logic             reset,
   input  logic             acq_enable,
   input  logic             adc_word_sync,
   input  logic [N_CH-1:0]  adc_sdata,
   adc_serial_capture_if.master m,
   output logic [31:0]      frame_cnt,
   output logic [15:0]      drop_cnt,
   output logic             overrun,
   output logic             sync_err,
   input  logic             clear_flags
);

   localparam int                PTR_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [4:0]        LAST_BIT = 5'(ADC_BITS - 1);
   localparam logic [PTR_W-1:0]  LAST_CH  = PTR_W'(N_CH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LOAD  = 2'd2
   } state_t;

   state_t               state, state_nxt;
   logic [4:0]           bit_cnt;
   logic [ADC_BITS-1:0]  sreg [N_CH];
   logic [ADC_BITS-1:0]  hold [N_CH];
   logic                 full;
   logic [PTR_W-1:0]     ptr;
   logic                 start, resync, beat, drain, load_ok, load_drop;

   function automatic logic [31:0] sign_ext(input logic [ADC_BITS-1:0] v);
      return {{(32-ADC_BITS){v[ADC_BITS-1]}}, v};
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign start     = adc_word_sync & acq_enable;
   assign resync    = (state == SHIFT) & adc_word_sync;
   assign beat      = full & m.tready;
   assign drain     = beat & (ptr == LAST_CH);
   // A buffer whose last beat leaves this cycle counts as free for the load.
   assign load_ok   = (state == LOAD) & (~full | drain);
   assign load_drop = (state == LOAD) & full & ~drain;

   assign m.tvalid = full;
   assign m.tdata  = sign_ext(hold[ptr]);
   assign m.tuser  = 4'(ptr);
   assign m.tlast  = full & (ptr == LAST_CH);

   // Capture FSM state register.
   always_ff @(posedge data_clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Capture FSM next state; a sync inside SHIFT realigns without leaving SHIFT.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (!adc_word_sync && bit_cnt == LAST_BIT) state_nxt = LOAD;
         LOAD:    state_nxt = start ? SHIFT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Bit counter and per-lane shift registers; the resync edge itself carries no data bit.
   always_ff @(posedge data_clk or posedge reset) begin
      if (reset) begin
         bit_cnt <= '0;
         for (int i = 0; i < N_CH; i++) sreg[i] <= '0;
      end else if (state == SHIFT) begin
         if (adc_word_sync) begin
            bit_cnt <= '0;
         end else begin
            bit_cnt <= (bit_cnt == LAST_BIT) ? 5'd0 : bit_cnt + 5'd1;
            for (int i = 0; i < N_CH; i++) sreg[i] <= {sreg[i][ADC_BITS-2:0], adc_sdata[i]};
         end
      end else begin
         bit_cnt <= '0;
      end
   end

   // Holding buffer and beat pointer; a load overrides the drain of the same cycle.
   always_ff @(posedge data_clk or posedge reset) begin
      if (reset) begin
         full <= 1'b0;
         ptr  <= '0;
         for (int i = 0; i < N_CH; i++) hold[i] <= '0;
      end else begin
         if (beat) begin
            if (ptr == LAST_CH) begin
               full <= 1'b0;
               ptr  <= '0;
            end else begin
               ptr <= ptr + PTR_W'(1);
            end
         end
         if (load_ok) begin
            full <= 1'b1;
            ptr  <= '0;
            for (int i = 0; i < N_CH; i++) hold[i] <= sreg[i];
         end
      end
   end

   // Frame/drop counters and sticky flags; a new event beats a simultaneous clear.
   always_ff @(posedge data_clk or posedge reset) begin
      if (reset) begin
         frame_cnt <= '0;
         drop_cnt  <= '0;
         overrun   <= 1'b0;
         sync_err  <= 1'b0;
      end else begin
         if (load_ok) frame_cnt <= frame_cnt + 32'd1;

         if (load_drop)        overrun <= 1'b1;
         else if (clear_flags) overrun <= 1'b0;

         if (resync)           sync_err <= 1'b1;
         else if (clear_flags) sync_err <= 1'b0;

         if (clear_flags)    drop_cnt <= load_drop ? 16'd1 : 16'd0;
         else if (load_drop) drop_cnt <= sat_inc(drop_cnt);
      end
   end

endmodule

// File: tb/tb_adc_serial_capture.sv
// Bench for adc_serial_capture: directed scenarios followed by randomized traffic,
// all checked against a frame-level reference model.
module tb_adc_serial_capture;
   localparam int N_CH = 8;
   localparam int B    = 18;

   logic            data_clk = 1'b0;
   logic            reset    = 1'b1;
   logic            acq_enable = 1'b0;
   logic            adc_word_sync = 1'b0;
   logic [N_CH-1:0] adc_sdata = '0;
   logic            clear_flags = 1'b0;
   logic [31:0]     frame_cnt;
   logic [15:0]     drop_cnt;
   logic            overrun, sync_err;

   adc_serial_capture_if m_if ();

   adc_serial_capture #(.N_CH(N_CH), .ADC_BITS(B)) dut (
      .data_clk      (data_clk),
      .reset         (reset),
      .acq_enable    (acq_enable),
      .adc_word_sync (adc_word_sync),
      .adc_sdata     (adc_sdata),
      .m             (m_if),
      .frame_cnt     (frame_cnt),
      .drop_cnt      (drop_cnt),
      .overrun       (overrun),
      .sync_err      (sync_err),
      .clear_flags   (clear_flags)
   );

   always #5 data_clk = ~data_clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Transmitter: new random sample set at every sync, serialized MSB first after it.
   int txv[N_CH];
   int forced[N_CH];
   bit use_forced = 0;
   int tx_pos = B;
   int hs_cnt = 0;

   // Reference model (frame/time level).
   int  t = 0;
   bit  active = 0;
   int  fstart = 0;
   int  fv[N_CH];
   int  mh[N_CH];
   int  beats_left = 0;
   longint m_frame = 0;
   int  m_drop = 0;
   bit  m_ovr = 0, m_serr = 0;

   function automatic logic [31:0] sx(input int v);
      if (v >= (1 << (B-1))) return 32'(v - (1 << B));
      return 32'(v);
   endfunction

   task automatic model_reset();
      active = 0; beats_left = 0; m_frame = 0; m_drop = 0; m_ovr = 0; m_serr = 0;
      tx_pos = B;
   endtask

   task automatic model_step(input bit sync, input bit en, input bit rdy, input bit clr);
      bit drop, serr;
      drop = 0; serr = 0;
      if (beats_left > 0 && rdy) beats_left--;
      if (active && t <= fstart + B) begin
         if (sync) begin
            serr = 1; fstart = t; fv = txv;
         end
      end else if (active && t == fstart + B + 1) begin
         if (beats_left == 0) begin
            mh = fv; beats_left = N_CH; m_frame++;
         end else begin
            drop = 1;
         end
         if (sync && en) begin fstart = t; fv = txv; end
         else active = 0;
      end else if (sync && en) begin
         active = 1; fstart = t; fv = txv;
      end
      m_ovr  = drop ? 1'b1 : (clr ? 1'b0 : m_ovr);
      m_serr = serr ? 1'b1 : (clr ? 1'b0 : m_serr);
      if (clr)       m_drop = drop ? 1 : 0;
      else if (drop) m_drop = (m_drop >= 65535) ? 65535 : m_drop + 1;
      t++;
   endtask

   task automatic check_outputs();
      int idx;
      chk("tvalid", 32'(m_if.tvalid), 32'(beats_left > 0));
      if (beats_left > 0) begin
         idx = N_CH - beats_left;
         chk("tdata", m_if.tdata, sx(mh[idx]));
         chk("tuser", 32'(m_if.tuser), 32'(idx));
         chk("tlast", 32'(m_if.tlast), 32'(beats_left == 1));
      end else begin
         chk("tlast_idle", 32'(m_if.tlast), 32'd0);
      end
      chk("frame_cnt", frame_cnt, 32'(m_frame));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("sync_err", 32'(sync_err), 32'(m_serr));
   endtask

   task automatic tick(input bit sync, input bit en, input bit rdy, input bit clr);
      @(negedge data_clk);
      adc_word_sync = sync;
      acq_enable    = en;
      m_if.tready   = rdy;
      clear_flags   = clr;
      if (sync) begin
         for (int i = 0; i < N_CH; i++)
            txv[i] = use_forced ? forced[i] : int'($urandom_range(0, (1 << B) - 1));
         use_forced = 0;
         tx_pos = 0;
         adc_sdata = N_CH'($urandom);
      end else if (tx_pos < B) begin
         for (int i = 0; i < N_CH; i++) adc_sdata[i] = 1'((txv[i] >> (B - 1 - tx_pos)) & 1);
         tx_pos++;
      end else begin
         adc_sdata = N_CH'($urandom);
      end
      if (m_if.tvalid && rdy) hs_cnt++;
      @(posedge data_clk);
      model_step(sync, en, rdy, clr);
      #2;
      check_outputs();
   endtask

   task automatic do_reset();
      @(negedge data_clk);
      reset = 1'b1;
      adc_word_sync = 0; acq_enable = 0; clear_flags = 0; m_if.tready = 0;
      #1;
      chk("rst_tvalid", 32'(m_if.tvalid), 32'd0);
      chk("rst_tlast", 32'(m_if.tlast), 32'd0);
      chk("rst_tdata", m_if.tdata, 32'd0);
      chk("rst_tuser", 32'(m_if.tuser), 32'd0);
      chk("rst_frame", frame_cnt, 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);
      chk("rst_serr", 32'(sync_err), 32'd0);
      model_reset();
      repeat (2) @(posedge data_clk);
      @(negedge data_clk);
      reset = 1'b0;
   endtask

   initial begin
      int n, gap, since;
      bit s, en, rdy, clr;
      m_if.tready = 1'b0;

      // Directed frame with known extreme samples.
      do_reset();
      repeat (10) tick(0, 1, 1, 0);
      for (int i = 0; i < N_CH; i++) forced[i] = int'($urandom_range(0, (1 << B) - 1));
      forced[0] = 'h20001;
      forced[7] = 'h1FFFF;
      use_forced = 1;
      tick(1, 1, 1, 0);
      n = 0;
      do begin
         tick(0, 1, 1, 0);
         n++;
      end while (!m_if.tvalid && n < 40);
      chk("t1_latency", 32'(n), 32'd19);
      chk("t1_beat0", m_if.tdata, 32'hFFFE0001);
      chk("t1_tlast0", 32'(m_if.tlast), 32'd0);
      repeat (7) tick(0, 1, 1, 0);
      chk("t1_beat7", m_if.tdata, 32'h0001FFFF);
      chk("t1_tlast7", 32'(m_if.tlast), 32'd1);
      chk("t1_tuser7", 32'(m_if.tuser), 32'd7);
      tick(0, 1, 1, 0);
      chk("t1_frames", frame_cnt, 32'd1);
      repeat (5) tick(0, 1, 1, 0);

      // Continuous 20-cycle frames with an always-ready sink.
      hs_cnt = 0;
      for (int f = 0; f < 100; f++) begin
         tick(1, 1, 1, 0);
         repeat (19) tick(0, 1, 1, 0);
      end
      repeat (30) tick(0, 1, 1, 0);
      chk("t2_beats", 32'(hs_cnt), 32'd800);
      chk("t2_frames", frame_cnt, 32'd101);
      chk("t2_drop", 32'(drop_cnt), 32'd0);
      chk("t2_ovr", 32'(overrun), 32'd0);

      // Sink stalled for 60 cycles across four frames.
      for (int c = 0; c < 100; c++)
         tick((c % 20 == 0) && (c < 80), 1, !(c >= 19 && c < 79), 0);
      chk("t3_ovr", 32'(overrun), 32'd1);
      chk("t3_drop", 32'(drop_cnt), 32'd3);
      chk("t3_frames", frame_cnt, 32'd102);
      tick(0, 1, 1, 1);
      chk("t3_clr_drop", 32'(drop_cnt), 32'd0);
      chk("t3_clr_ovr", 32'(overrun), 32'd0);

      // Second sync seven cycles into a frame.
      tick(1, 1, 1, 0);
      repeat (6) tick(0, 1, 1, 0);
      tick(1, 1, 1, 0);
      repeat (35) tick(0, 1, 1, 0);
      chk("t4_serr", 32'(sync_err), 32'd1);
      chk("t4_frames", frame_cnt, 32'd103);
      tick(0, 1, 1, 1);

      // acq_enable dropped mid-frame; following sync ignored.
      tick(1, 1, 1, 0);
      repeat (4) tick(0, 1, 1, 0);
      repeat (15) tick(0, 0, 1, 0);
      tick(1, 0, 1, 0);
      repeat (30) tick(0, 0, 1, 0);
      chk("t5_frames", frame_cnt, 32'd104);

      // Reset mid-SHIFT, then mid-stream, then a clean frame.
      tick(1, 1, 1, 0);
      repeat (8) tick(0, 1, 1, 0);
      do_reset();
      tick(1, 1, 1, 0);
      n = 0;
      do begin
         tick(0, 1, 1, 0);
         n++;
      end while (!m_if.tvalid && n < 40);
      chk("t6_latency", 32'(n), 32'd19);
      repeat (3) tick(0, 1, 1, 0);
      repeat (2) tick(0, 1, 0, 0);
      do_reset();
      tick(1, 1, 1, 0);
      repeat (30) tick(0, 1, 1, 0);
      chk("t6_frames", frame_cnt, 32'd1);

      // Randomized traffic: irregular sync spacing, back-pressure, enable and clears.
      gap = 20; since = 0;
      for (int k = 0; k < 4000; k++) begin
         s = (since >= gap);
         if (s) begin
            since = 0;
            case ($urandom_range(0, 7))
               0: gap = 7;
               1: gap = 12;
               2: gap = 18;
               3: gap = 19;
               4: gap = 20;
               5: gap = 21;
               6: gap = 24;
               default: gap = 30;
            endcase
         end else begin
            since++;
         end
         en  = ($urandom_range(0, 9) != 0);
         rdy = ($urandom_range(0, 9) < 8);
         clr = ($urandom_range(0, 49) == 0);
         tick(s, en, rdy, clr);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
